mxu_pe_pipelined: RTL and testbench

Registered, parametrised weight-stationary processing element for the MXU systolic array. It replaces the combinational forward PE with a version that has these features:
- one-cycle registered passthroughs in both array directions;
- valid-qualified activation and load streams;
- a double-buffered (shadow/active) weight, so the next tile's weights preload while the current tile computes;
- optional saturating accumulation.

The array instantiates one per grid position. Columns chain through the load and swap ports; rows chain through the activation ports.

---
 rtl/mxu_pkg.sv | 38 +++
 rtl/mxu_mac_sat.sv | 44 ++++
 rtl/mxu_pe_pipelined.sv | 101 ++++++++++
 tb/tb_mxu_pe_pipelined.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mxu_pkg.sv
// Shared widths and helpers for the MXU processing elements.
//   MXU_DATA_W / MXU_ACC_W / MXU_IDX_W : default activation, accumulator, index widths
//   sat_add : clamps a sign-extended sum to a signed acc_w-bit range and flags overflow
package mxu_pkg;

  localparam int unsigned MXU_DATA_W = 8;
  localparam int unsigned MXU_ACC_W  = 24;
  localparam int unsigned MXU_IDX_W  = 8;

  // Widest accumulator sat_add can handle; sums are sign-extended to this width.
  localparam int unsigned MXU_MAX_W  = 64;

  typedef struct packed {
    logic [MXU_MAX_W-1:0] value;
    logic                 ovf;
  } sat_res_t;

  // Clamp sum into [-2^(acc_w-1), 2^(acc_w-1)-1]; ovf is set whenever clamping happened.
  function automatic sat_res_t sat_add(input logic signed [MXU_MAX_W-1:0] sum,
                                       input int unsigned acc_w);
    logic signed [MXU_MAX_W-1:0] max_v;
    logic signed [MXU_MAX_W-1:0] min_v;
    sat_res_t                    res;
    max_v = $signed((64'd1 << (acc_w - 1)) - 64'd1);
    min_v = ~max_v;
    res.value = sum;
    res.ovf   = 1'b0;
    if (sum > max_v) begin
      res.value = max_v;
      res.ovf   = 1'b1;
    end else if (sum < min_v) begin
      res.value = min_v;
      res.ovf   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mxu_mac_sat.sv
// Combinational multiply-accumulate: result = psum + weight*act (all signed).
//   weight, act : DATA_W two's complement operands
//   psum        : ACC_W incoming partial sum
//   result      : wrapped (SATURATE=0) or clamped (SATURATE=1) ACC_W sum
//   ovf         : true sum did not fit the signed ACC_W range
module mxu_mac_sat
  import mxu_pkg::*;
#(
  parameter int unsigned DATA_W   = MXU_DATA_W,
  parameter int unsigned ACC_W    = MXU_ACC_W,
  parameter int unsigned SATURATE = 0
) (
  input  logic [DATA_W-1:0] weight,
  input  logic [DATA_W-1:0] act,
  input  logic [ACC_W-1:0]  psum,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W:0]      product_ext;
  logic signed [ACC_W:0]      psum_ext;
  logic signed [ACC_W:0]      sum;
  sat_res_t                   sat;
  logic                       unused_sat_hi;

  always_comb begin
    product     = $signed(weight) * $signed(act);
    product_ext = {{(ACC_W + 1 - 2*DATA_W){product[2*DATA_W-1]}}, product};
    psum_ext    = {psum[ACC_W-1], psum};
    // One guard bit is enough: ACC_W >= 2*DATA_W keeps |product| below 2^(ACC_W-1).
    sum         = psum_ext + product_ext;
    sat         = sat_add({{(MXU_MAX_W - ACC_W - 1){sum[ACC_W]}}, sum}, ACC_W);
    ovf         = sat.ovf;
    if (SATURATE != 0) begin
      result = sat.value[ACC_W-1:0];
    end else begin
      result = sum[ACC_W-1:0];
    end
  end

  assign unused_sat_hi = ^sat.value[MXU_MAX_W-1:ACC_W];

endmodule

// File: rtl/mxu_pe_pipelined.sv
// Registered weight-stationary PE with double-buffered weight.
//   load_*_in  -> load_*_out  : column load chain, 1-cycle registered passthrough
//   swap_in    -> swap_out    : column swap chain; swap copies shadow weight into active
//   act_*_in   -> act_*_out   : row activation chain
//   psum_in    -> result_out  : psum + active_weight*act, valid-qualified, with ovf_out
//   shadow_full_out           : shadow weight written since the last swap
module mxu_pe_pipelined
  import mxu_pkg::*;
#(
  parameter int unsigned DATA_W   = MXU_DATA_W,
  parameter int unsigned ACC_W    = MXU_ACC_W,
  parameter int unsigned IDX_W    = MXU_IDX_W,
  parameter int unsigned Y_INDEX  = 0,
  parameter int unsigned SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid_in,
  input  logic [IDX_W-1:0]  load_target_y_in,
  input  logic [DATA_W-1:0] load_weight_in,
  input  logic              swap_in,
  input  logic              act_valid_in,
  input  logic [DATA_W-1:0] act_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic              load_valid_out,
  output logic [IDX_W-1:0]  load_target_y_out,
  output logic [DATA_W-1:0] load_weight_out,
  output logic              swap_out,
  output logic              act_valid_out,
  output logic [DATA_W-1:0] act_out,
  output logic              result_valid_out,
  output logic [ACC_W-1:0]  result_out,
  output logic              ovf_out,
  output logic              shadow_full_out
);

  logic [DATA_W-1:0] shadow_w_q;
  logic [DATA_W-1:0] active_w_q;
  logic              load_hit;
  logic [ACC_W-1:0]  mac_result;
  logic              mac_ovf;

  assign load_hit = load_valid_in && (32'(load_target_y_in) == Y_INDEX);

  // MAC sees active_w_q before any same-cycle swap lands.
  mxu_mac_sat #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_mac (
    .weight (active_w_q),
    .act    (act_in),
    .psum   (psum_in),
    .result (mac_result),
    .ovf    (mac_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_w_q        <= '0;
      active_w_q        <= '0;
      shadow_full_out   <= 1'b0;
      load_valid_out    <= 1'b0;
      load_target_y_out <= '0;
      load_weight_out   <= '0;
      swap_out          <= 1'b0;
      act_valid_out     <= 1'b0;
      act_out           <= '0;
      result_valid_out  <= 1'b0;
      result_out        <= '0;
      ovf_out           <= 1'b0;
    end else begin
      load_valid_out    <= load_valid_in;
      load_target_y_out <= load_target_y_in;
      load_weight_out   <= load_weight_in;
      swap_out          <= swap_in;
      act_valid_out     <= act_valid_in;
      result_valid_out  <= act_valid_in;

      // Non-blocking reads give the swap the pre-load shadow value.
      if (swap_in) begin
        active_w_q <= shadow_w_q;
      end
      if (load_hit) begin
        shadow_w_q <= load_weight_in;
      end
      if (load_hit) begin
        shadow_full_out <= 1'b1;
      end else if (swap_in) begin
        shadow_full_out <= 1'b0;
      end

      if (act_valid_in) begin
        act_out    <= act_in;
        result_out <= mac_result;
        ovf_out    <= mac_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mxu_pe_pipelined.sv
module tb_mxu_pe_pipelined;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 24;
  localparam int unsigned IW = 8;

  typedef struct {
    logic          lv;
    logic [IW-1:0] ty;
    logic [DW-1:0] lw;
    logic          sw;
    logic          av;
    logic [DW-1:0] a;
    logic [AW-1:0] ps;
    logic          e_rv;
    logic [AW-1:0] e_res;
    logic [AW-1:0] e_res_sat;
    logic          e_ovf;
    logic          e_ovf_sat;
    logic          e_sf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid_in = 1'b0;
  logic [IW-1:0] load_target_y_in = '0;
  logic [DW-1:0] load_weight_in = '0;
  logic          swap_in = 1'b0;
  logic          act_valid_in = 1'b0;
  logic [DW-1:0] act_in = '0;
  logic [AW-1:0] psum_in = '0;

  logic          load_valid_out, swap_out, act_valid_out, result_valid_out, ovf_out;
  logic          shadow_full_out;
  logic [IW-1:0] load_target_y_out;
  logic [DW-1:0] load_weight_out, act_out;
  logic [AW-1:0] result_out;

  logic          s_load_valid_out, s_swap_out, s_act_valid_out, s_result_valid_out, s_ovf_out;
  logic          s_shadow_full_out;
  logic [IW-1:0] s_load_target_y_out;
  logic [DW-1:0] s_load_weight_out, s_act_out;
  logic [AW-1:0] s_result_out;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mxu_pe_pipelined #(
    .DATA_W(DW), .ACC_W(AW), .IDX_W(IW), .Y_INDEX(2), .SATURATE(0)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid_in(load_valid_in), .load_target_y_in(load_target_y_in),
    .load_weight_in(load_weight_in), .swap_in(swap_in),
    .act_valid_in(act_valid_in), .act_in(act_in), .psum_in(psum_in),
    .load_valid_out(load_valid_out), .load_target_y_out(load_target_y_out),
    .load_weight_out(load_weight_out), .swap_out(swap_out),
    .act_valid_out(act_valid_out), .act_out(act_out),
    .result_valid_out(result_valid_out), .result_out(result_out),
    .ovf_out(ovf_out), .shadow_full_out(shadow_full_out)
  );

  mxu_pe_pipelined #(
    .DATA_W(DW), .ACC_W(AW), .IDX_W(IW), .Y_INDEX(2), .SATURATE(1)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .load_valid_in(load_valid_in), .load_target_y_in(load_target_y_in),
    .load_weight_in(load_weight_in), .swap_in(swap_in),
    .act_valid_in(act_valid_in), .act_in(act_in), .psum_in(psum_in),
    .load_valid_out(s_load_valid_out), .load_target_y_out(s_load_target_y_out),
    .load_weight_out(s_load_weight_out), .swap_out(s_swap_out),
    .act_valid_out(s_act_valid_out), .act_out(s_act_out),
    .result_valid_out(s_result_valid_out), .result_out(s_result_out),
    .ovf_out(s_ovf_out), .shadow_full_out(s_shadow_full_out)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [IW-1:0] ty, input logic [DW-1:0] lw,
                       input logic sw, input logic av, input logic [DW-1:0] a,
                       input logic [AW-1:0] ps);
    load_valid_in    = lv;
    load_target_y_in = ty;
    load_weight_in   = lw;
    swap_in          = sw;
    act_valid_in     = av;
    act_in           = a;
    psum_in          = ps;
  endtask

  task automatic add(input logic lv, input logic [IW-1:0] ty, input logic [DW-1:0] lw,
                     input logic sw, input logic av, input logic [DW-1:0] a,
                     input logic [AW-1:0] ps, input logic rv, input logic [AW-1:0] res,
                     input logic [AW-1:0] res_s, input logic ov, input logic ov_s,
                     input logic sf);
    vec_t v;
    v = '{lv, ty, lw, sw, av, a, ps, rv, res, res_s, ov, ov_s, sf};
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_zero_main"}, {31'd0, |{load_valid_out, load_target_y_out, load_weight_out,
          swap_out, act_valid_out, act_out, result_valid_out, result_out, ovf_out,
          shadow_full_out}}, 32'd0);
    check({tag, "_zero_sat"}, {31'd0, |{s_load_valid_out, s_load_target_y_out,
          s_load_weight_out, s_swap_out, s_act_valid_out, s_act_out, s_result_valid_out,
          s_result_out, s_ovf_out, s_shadow_full_out}}, 32'd0);
  endtask

  initial begin
    // lv ty lw sw | av a ps | rv res res_sat ovf ovf_sat shadow_full
    add(1, 2, 8'd5, 0,  0, 0, 0,          0, 0, 0, 0, 0, 1);           // preload 5
    add(0, 0, 0, 1,     0, 0, 0,          0, 0, 0, 0, 0, 0);           // swap -> active 5
    add(0, 0, 0, 0,     1, 8'd3, 24'd10,  1, 24'd25, 24'd25, 0, 0, 0); // 10+5*3
    add(1, 1, 8'd9, 0,  0, 0, 0,          0, 24'd25, 24'd25, 0, 0, 0); // other PE's beat
    add(0, 0, 0, 1,     0, 0, 0,          0, 24'd25, 24'd25, 0, 0, 0); // shadow still 5
    add(0, 0, 0, 0,     1, 8'd2, 24'd0,   1, 24'd10, 24'd10, 0, 0, 0);
    add(1, 2, 8'd7, 0,  0, 0, 0,          0, 24'd10, 24'd10, 0, 0, 1); // shadow 7
    add(0, 0, 0, 0,     1, 8'd2, 24'd0,   1, 24'd10, 24'd10, 0, 0, 1); // still active 5
    add(0, 0, 0, 1,     0, 0, 0,          0, 24'd10, 24'd10, 0, 0, 0);
    add(0, 0, 0, 0,     1, 8'd2, 24'd0,   1, 24'd14, 24'd14, 0, 0, 0);
    add(1, 2, 8'd4, 0,  0, 0, 0,          0, 24'd14, 24'd14, 0, 0, 1); // shadow 4
    add(1, 2, 8'd9, 1,  0, 0, 0,          0, 24'd14, 24'd14, 0, 0, 1); // swap 4, load 9
    add(0, 0, 0, 0,     1, 8'd1, 24'd0,   1, 24'd4, 24'd4, 0, 0, 1);
    add(0, 0, 0, 1,     0, 0, 0,          0, 24'd4, 24'd4, 0, 0, 0);
    add(0, 0, 0, 0,     1, 8'd1, 24'd0,   1, 24'd9, 24'd9, 0, 0, 0);
    add(1, 2, 8'h80, 0, 0, 0, 0,          0, 24'd9, 24'd9, 0, 0, 1);   // weight -128
    add(0, 0, 0, 1,     0, 0, 0,          0, 24'd9, 24'd9, 0, 0, 0);
    add(0, 0, 0, 0,     1, 8'h80, 24'd0,  1, 24'h004000, 24'h004000, 0, 0, 0);
    add(0, 0, 0, 0,     1, 8'h7F, 24'd0,  1, 24'hFFC080, 24'hFFC080, 0, 0, 0);
    add(1, 2, 8'd1, 0,  0, 0, 0,          0, 24'hFFC080, 24'hFFC080, 0, 0, 1);
    add(0, 0, 0, 1,     0, 0, 0,          0, 24'hFFC080, 24'hFFC080, 0, 0, 0);
    add(0, 0, 0, 0,     1, 8'd1, 24'h7FFFFF, 1, 24'h800000, 24'h7FFFFF, 1, 1, 0);
    add(0, 0, 0, 0,     1, 8'd1, 24'd5,   1, 24'd6, 24'd6, 0, 0, 0);
    add(0, 0, 0, 0,     1, 8'hFF, 24'h800000, 1, 24'h7FFFFF, 24'h800000, 1, 1, 0);
    add(0, 0, 0, 0,     0, 8'd5, 24'd0,   0, 24'h7FFFFF, 24'h800000, 1, 1, 0); // hold

    // Reset state.
    #2;
    check_all_zero("reset_init");
    #10 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].lv, vecs[i].ty, vecs[i].lw, vecs[i].sw, vecs[i].av, vecs[i].a,
            vecs[i].ps);
      @(posedge clk);
      #1;
      check($sformatf("row%0d_result_valid", i), {31'd0, result_valid_out}, {31'd0, vecs[i].e_rv});
      check($sformatf("row%0d_result", i), {8'd0, result_out}, {8'd0, vecs[i].e_res});
      check($sformatf("row%0d_result_sat", i), {8'd0, s_result_out}, {8'd0, vecs[i].e_res_sat});
      check($sformatf("row%0d_ovf", i), {31'd0, ovf_out}, {31'd0, vecs[i].e_ovf});
      check($sformatf("row%0d_ovf_sat", i), {31'd0, s_ovf_out}, {31'd0, vecs[i].e_ovf_sat});
      check($sformatf("row%0d_shadow_full", i), {31'd0, shadow_full_out}, {31'd0, vecs[i].e_sf});
      check($sformatf("row%0d_passthrough", i),
            {13'd0, load_valid_out, load_target_y_out, load_weight_out, swap_out, act_valid_out},
            {13'd0, vecs[i].lv, vecs[i].ty, vecs[i].lw, vecs[i].sw, vecs[i].av});
    end

    // Mid-stream asynchronous reset with a loaded shadow and a live result.
    drive(1, 2, 8'd3, 0, 1, 8'd4, 24'd2);
    @(posedge clk);
    #1;
    check("pre_reset_result", {8'd0, result_out}, {8'd0, 24'd6}); // active 1: 2+1*4
    check("pre_reset_act_out", {24'd0, act_out}, 32'd4);
    check("pre_reset_shadow_full", {31'd0, shadow_full_out}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    #1 rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check("post_reset_swap_shadow_full", {31'd0, shadow_full_out}, 32'd0);
    drive(0, 0, 0, 0, 1, 8'd6, 24'd1);
    @(posedge clk);
    #1;
    check("post_reset_result", {8'd0, result_out}, {8'd0, 24'd1});
    check("post_reset_result_sat", {8'd0, s_result_out}, {8'd0, 24'd1});
    check("post_reset_valid", {31'd0, result_valid_out}, 32'd1);
    check("post_reset_act_out", {24'd0, act_out}, 32'd6);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
